// File: rtl/led_pattern_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer_pkg
//   Shared definitions for the LED pattern sequencer: bus widths, FSM state
//   encoding, pattern mode codes and the pattern helper functions. Firmware
//   model tests import this package to stay in lock-step with the hardware.
//
//   Bus widths come from the `ADDR_WIDTH / `APB_DATA_WIDTH defines; when the
//   shared configuration has not defined them they default to 32 bits.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package led_pattern_sequencer_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `APB_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SETUP     = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_NEXT      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  // Rotate left by n bits (n < DATA_W): the upper half of the doubled word
  // shifted left is exactly the rotated value.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d,
                                             input int unsigned n);
    logic [2*DATA_W-1:0] dd;
    dd = {d, d} << n;
    return dd[2*DATA_W-1:DATA_W];
  endfunction

  // Pattern value for the following step.
  function automatic logic [DATA_W-1:0] next_pattern(input mode_t m,
                                                     input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    case (m)
      MODE_WALK:   r = rotl(p, 1);
      MODE_COUNT:  r = p + DATA_W'(1);
      MODE_TOGGLE: r = ~p;
      default:     r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_apb.sv
// ---------------------------------------------------------------------------
// led_seq_apb_master
//   APB write-only master phase logic for the LED sequencer. The sequencer
//   FSM tells it which phase it is in (setup / access); this block drives the
//   APB control, address and data lines, reports completion on the ack cycle
//   and, when LEDSEQ_ACK_TIMEOUT_EN is defined, flags an access phase that
//   has waited TIMEOUT_CYCLES cycles without an ack.
//
//   Configuration macro: LEDSEQ_ACK_TIMEOUT_EN (undefined -> no timeout,
//   access waits indefinitely, timeout output tied low).
//
//   Ports
//     clk, reset      clock, asynchronous active-high reset
//     setup, access   current transfer phase from the sequencer FSM
//     addr, wdata     address / write data of the current transfer
//     apb_ack         slave ready
//     apb_*           APB master outputs (all zero outside setup/access)
//     done            access cycle in which the slave acked
//     timeout         last permitted access cycle passed without an ack
// ---------------------------------------------------------------------------
module led_seq_apb_master
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              setup,
  input  logic              access,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              apb_ack,
  output logic              apb_req,
  output logic              apb_psel,
  output logic              apb_rw,
  output logic              apb_enab,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_datai,
  output logic              done,
  output logic              timeout
);

  logic active;

  assign active    = setup | access;
  assign apb_req   = active;
  assign apb_psel  = active;
  assign apb_rw    = active;
  assign apb_enab  = access;
  assign apb_addr  = active ? addr  : '0;
  assign apb_datai = active ? wdata : '0;
  assign done      = access & apb_ack;

`ifdef LEDSEQ_ACK_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts completed un-acked access cycles; restarts whenever the access
  // phase ends, so each transfer gets its own budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (access && !apb_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = access & ~apb_ack & (wait_cnt == LAST_CNT);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;
  assign timeout        = 1'b0;
`endif

endmodule

// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//   Periodically writes a pattern to REG_NUM consecutive 32-bit-spaced LED
//   registers over APB. Each step writes base_addr + 4*i with the pattern
//   rotated left by i; after the step the pattern advances according to the
//   latched mode (walk / count / toggle / hold). Steps start every
//   STEP_CYCLES clocks; a step that overruns its slot is followed at once by
//   the next one (at most one pending step).
//
//   Configuration macro: LEDSEQ_ACK_TIMEOUT_EN (defined -> an access phase
//   without ack for TIMEOUT_CYCLES cycles sets err and halts sequencing;
//   undefined -> waits indefinitely, err tied low).
//
//   Ports
//     clk, reset      clock, asynchronous active-high reset
//     start, stop     begin sequencing / request halt at end of step
//     mode            pattern select (0 walk, 1 count, 2 toggle, 3 hold)
//     init_pattern    seed pattern, latched on start
//     base_addr       address of LED register R0, latched on start
//     apb_*           APB master interface (apb_datao unused)
//     busy            high in every state except IDLE
//     step_done       one-cycle pulse as each step completes
//     step_count      completed steps, wraps at 16 bits
//     err             sticky ack-timeout flag
// ---------------------------------------------------------------------------
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int REG_NUM        = 4,
  parameter int STEP_CYCLES    = 50000000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] init_pattern,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              apb_req,
  output logic              apb_psel,
  output logic              apb_rw,
  output logic              apb_enab,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_datai,
  input  logic              apb_ack,
  input  logic [DATA_W-1:0] apb_datao,
  output logic              busy,
  output logic              step_done,
  output logic [15:0]       step_count,
  output logic              err
);

  localparam int               IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REG_NUM - 1);
  localparam int               TICK_W    = $clog2(STEP_CYCLES);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_CYCLES - 1);

  state_t              state_q, state_d;
  mode_t               mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   pattern_q;
  logic [IDX_W-1:0]    idx_q;
  logic [TICK_W-1:0]   tick_q;
  logic [15:0]         step_count_q;
  logic                stop_pending_q;
  logic                tick_pending_q;

  logic                tick_wrap;
  logic                in_step;
  logic                accept;
  logic                finish_step;
  logic                xfer_done;
  logic                xfer_timeout;
  logic                unused_datao;

  assign unused_datao = ^apb_datao;
  assign tick_wrap    = (tick_q == LAST_TICK);
  assign in_step      = (state_q == ST_SETUP) || (state_q == ST_ACCESS) ||
                        (state_q == ST_NEXT);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    finish_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_WAIT_TICK: begin
        if (stop)           state_d = ST_IDLE;
        else if (tick_wrap) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (xfer_done)         state_d = ST_NEXT;
        else if (xfer_timeout) state_d = ST_IDLE;
      end
      ST_NEXT: begin
        if (idx_q != LAST_IDX) begin
          state_d = ST_SETUP;
        end else begin
          finish_step = 1'b1;
          // A slot boundary seen during the step (or right now) starts the
          // next step immediately; a stop request always wins.
          if (stop_pending_q || stop)          state_d = ST_IDLE;
          else if (tick_pending_q || tick_wrap) state_d = ST_SETUP;
          else                                  state_d = ST_WAIT_TICK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: tick counter, pattern, register index, step counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q         <= MODE_WALK;
      base_q         <= '0;
      pattern_q      <= '0;
      idx_q          <= '0;
      tick_q         <= '0;
      step_count_q   <= '0;
      stop_pending_q <= 1'b0;
      tick_pending_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || tick_wrap) tick_q <= '0;
      else                                 tick_q <= tick_q + TICK_W'(1);

      if (accept) begin
        mode_q    <= mode_t'(mode);
        base_q    <= base_addr;
        pattern_q <= init_pattern;
        idx_q     <= '0;
      end else if (state_q == ST_NEXT) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end

      if (finish_step) begin
        pattern_q    <= next_pattern(mode_q, pattern_q);
        step_count_q <= step_count_q + 16'd1;
      end

      if (state_d == ST_IDLE)    stop_pending_q <= 1'b0;
      else if (in_step && stop)  stop_pending_q <= 1'b1;

      if (finish_step || state_d == ST_IDLE) tick_pending_q <= 1'b0;
      else if (in_step && tick_wrap)         tick_pending_q <= 1'b1;
    end
  end

`ifdef LEDSEQ_ACK_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             err_q <= 1'b0;
    else if (accept)       err_q <= 1'b0;
    else if (xfer_timeout) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // APB phase logic
  // -------------------------------------------------------------------------
  led_seq_apb_master #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_apb (
    .clk       (clk),
    .reset     (reset),
    .setup     (state_q == ST_SETUP),
    .access    (state_q == ST_ACCESS),
    .addr      (base_q + (ADDR_W'(idx_q) << 2)),
    .wdata     (rotl(pattern_q, 32'(idx_q))),
    .apb_ack   (apb_ack),
    .apb_req   (apb_req),
    .apb_psel  (apb_psel),
    .apb_rw    (apb_rw),
    .apb_enab  (apb_enab),
    .apb_addr  (apb_addr),
    .apb_datai (apb_datai),
    .done      (xfer_done),
    .timeout   (xfer_timeout)
  );

  assign busy       = (state_q != ST_IDLE);
  assign step_done  = finish_step;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
//   Self-checking bench for led_pattern_sequencer with REG_NUM=4,
//   STEP_CYCLES=20, TIMEOUT_CYCLES=8, base address 0x1000. A slave/monitor
//   process acks transfers after a programmable delay and compares each
//   completed write against a scoreboard of expected writes. Timeout checks
//   are compiled in when LEDSEQ_ACK_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;
  import led_pattern_sequencer_pkg::*;

  localparam int REG_NUM        = 4;
  localparam int STEP_CYCLES    = 20;
  localparam int TIMEOUT_CYCLES = 8;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(32'h1000);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DATA_W-1:0] init_pattern = '0;
  logic [ADDR_W-1:0] base_addr = BASE;
  logic              apb_req, apb_psel, apb_rw, apb_enab;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_datai;
  logic              apb_ack = 1'b0;
  logic [DATA_W-1:0] apb_datao = '0;
  logic              busy, step_done, err;
  logic [15:0]       step_count;

  led_pattern_sequencer #(
    .REG_NUM        (REG_NUM),
    .STEP_CYCLES    (STEP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .init_pattern (init_pattern),
    .base_addr    (base_addr),
    .apb_req      (apb_req),
    .apb_psel     (apb_psel),
    .apb_rw       (apb_rw),
    .apb_enab     (apb_enab),
    .apb_addr     (apb_addr),
    .apb_datai    (apb_datai),
    .apb_ack      (apb_ack),
    .apb_datao    (apb_datao),
    .busy         (busy),
    .step_done    (step_done),
    .step_count   (step_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] init;
    int                ack_dly;
    logic [DATA_W-1:0] exp_r0_step2;
    int                exp_gap;
  } vec_t;

  wr_t               sb_q[$];
  int unsigned       setup_cyc[$];
  logic [DATA_W-1:0] obs_data[$];
  int                ack_delay = 0;
  bit                ack_never = 1'b0;
  int                enab_len  = 0;
  int                n_checks  = 0;
  int                n_pass    = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model, written as a bit-at-a-time rotate.
  function automatic logic [DATA_W-1:0] model_rotl(input logic [DATA_W-1:0] p,
                                                   input int n);
    logic [DATA_W-1:0] r;
    r = p;
    for (int k = 0; k < n; k++) r = {r[DATA_W-2:0], r[DATA_W-1]};
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] model_next(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] p);
    case (m)
      2'd0:    return model_rotl(p, 1);
      2'd1:    return p + 1;
      2'd2:    return ~p;
      default: return p;
    endcase
  endfunction

  task automatic push_steps(input logic [1:0] m, input logic [DATA_W-1:0] init,
                            input int steps);
    logic [DATA_W-1:0] p;
    wr_t w;
    p = init;
    for (int s = 0; s < steps; s++) begin
      for (int i = 0; i < REG_NUM; i++) begin
        w.addr = BASE + ADDR_W'(4 * i);
        w.data = model_rotl(p, i);
        sb_q.push_back(w);
      end
      p = model_next(m, p);
    end
  endtask

  // Slave + monitor: acks each access after ack_delay wait cycles and checks
  // the completed write against the scoreboard.
  initial begin : slave_monitor
    int unsigned       cyc;
    bit                prev_ack;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    wr_t               e;
    cyc = 0;
    prev_ack = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_ack) check("apb_idle_after_ack", {apb_psel, apb_enab}, 2'b00);
      prev_ack = 1'b0;
      apb_ack  = 1'b0;
      if (apb_psel && !apb_enab) begin
        setup_cyc.push_back(cyc);
        check("setup_req_rw", {apb_req, apb_rw}, 2'b11);
        hold_addr = apb_addr;
        hold_data = apb_datai;
        enab_len  = 0;
      end else if (apb_psel && apb_enab) begin
        enab_len++;
        check("access_addr_stable", apb_addr, hold_addr);
        check("access_data_stable", apb_datai, hold_data);
        if (!ack_never && enab_len == ack_delay + 1) begin
          apb_ack  = 1'b1;
          prev_ack = 1'b1;
          obs_data.push_back(apb_datai);
          if (sb_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("write_addr", apb_addr, e.addr);
            check("write_data", apb_datai, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_never = 1'b0;
    sb_q.delete();
    setup_cyc.delete();
    obs_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge of the n-th step_done pulse.
  task automatic wait_steps(input int n, input int budget);
    int  cnt;
    bit  prev_sd;
    cnt = 0;
    prev_sd = 1'b0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      @(negedge clk);
      if (step_done) begin
        cnt++;
        check("step_done_single_cycle", prev_sd, 1'b0);
      end
      prev_sd = step_done;
    end
    if (cnt < n) check("step_done_timeout", cnt, n);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) @(negedge clk);
    if (busy) check("wait_idle_timeout", busy, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[5];

  initial begin : main
    vecs[0] = '{2'd0, 32'h0000_0001, 0, 32'h0000_0002, 20};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 0, 32'h0000_0000, 20};
    vecs[2] = '{2'd2, 32'h0000_00F0, 1, 32'hFFFF_FF0F, 20};
    vecs[3] = '{2'd3, 32'h8000_0001, 5, 32'h8000_0001, 32};
    vecs[4] = '{2'd0, 32'h8000_0000, 2, 32'h0000_0001, 20};

    // Reset state
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_apb_ctrl", {apb_req, apb_psel, apb_rw, apb_enab}, 4'b0);
    check("rst_apb_addr", apb_addr, '0);
    check("rst_apb_data", apb_datai, '0);
    check("rst_step_count", step_count, 16'd0);
    check("rst_flags", {step_done, err}, 2'b00);

    // Start and stop together in IDLE stays idle
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle_busy", busy, 1'b0);
    @(negedge clk);
    check("start_stop_idle_setups", setup_cyc.size(), 0);

    // Table-driven two-step runs
    for (int v = 0; v < 5; v++) begin
      do_reset();
      ack_delay    = vecs[v].ack_dly;
      mode         = vecs[v].mode;
      init_pattern = vecs[v].init;
      push_steps(vecs[v].mode, vecs[v].init, 2);
      pulse_start();
      wait_steps(2, 200);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("vec_busy_after_stop", busy, 1'b0);
      check("vec_step_count", step_count, 16'd2);
      check("vec_sb_drained", sb_q.size(), 0);
      check("vec_setup_total", setup_cyc.size(), 2 * REG_NUM);
      if (setup_cyc.size() > REG_NUM)
        check("vec_step_gap", setup_cyc[REG_NUM] - setup_cyc[0], vecs[v].exp_gap);
      if (obs_data.size() > REG_NUM)
        check("vec_step2_r0", obs_data[REG_NUM], vecs[v].exp_r0_step2);
    end

    // Stop in WAIT_TICK halts on the next cycle
    do_reset();
    ack_delay = 0;
    mode = 2'd0;
    init_pattern = 32'h1;
    push_steps(2'd0, 32'h1, 1);
    pulse_start();
    wait_steps(1, 100);
    repeat (3) @(negedge clk);
    check("wait_tick_busy", busy, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("wait_tick_stop_idle", busy, 1'b0);

    // Stop during the write to 0x1004; start/config changes while busy ignored
    do_reset();
    ack_delay = 1;
    mode = 2'd0;
    init_pattern = 32'h1;
    push_steps(2'd0, 32'h1, 1);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (apb_psel && !apb_enab && apb_addr == ADDR_W'(32'h1004)) break;
      @(negedge clk);
    end
    check("stop_seen_0x1004", apb_addr, ADDR_W'(32'h1004));
    stop = 1'b1;
    start = 1'b1;
    base_addr = ADDR_W'(32'h2000);
    init_pattern = 32'h55;
    mode = 2'd1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    wait_idle(100);
    check("stop_sb_drained", sb_q.size(), 0);
    check("stop_setups", setup_cyc.size(), REG_NUM);
    check("stop_step_count", step_count, 16'd1);
    repeat (50) @(negedge clk);
    check("stop_no_more_setups", setup_cyc.size(), REG_NUM);
    check("stop_stays_idle", busy, 1'b0);
    base_addr = BASE;
    mode = 2'd0;
    init_pattern = 32'h1;

    // Reset pulse during ACCESS of the second step
    do_reset();
    ack_delay = 3;
    push_steps(2'd0, 32'h1, 1);
    pulse_start();
    wait_steps(1, 100);
    for (int i = 0; i < 40; i++) begin
      if (apb_enab) break;
      @(negedge clk);
    end
    check("rstmid_in_access", apb_enab, 1'b1);
    check("rstmid_count_before", step_count, 16'd1);
    reset = 1'b1;
    #1;
    check("rstmid_apb_ctrl", {apb_req, apb_psel, apb_rw, apb_enab}, 4'b0);
    check("rstmid_apb_addr_data", {apb_addr, apb_datai}, '0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_step_count", step_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    setup_cyc.delete();
    obs_data.delete();
    ack_delay = 0;
    push_steps(2'd0, 32'h1, 1);
    pulse_start();
    check("start_after_reset_setup", {apb_psel, apb_enab}, 2'b10);
    wait_steps(1, 100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("start_after_reset_sb", sb_q.size(), 0);

`ifdef LEDSEQ_ACK_TIMEOUT_EN
    // Ack never returned: err after TIMEOUT_CYCLES access cycles, then IDLE
    do_reset();
    ack_never = 1'b1;
    pulse_start();
    wait_idle(60);
    check("tmo_idle", busy, 1'b0);
    check("tmo_err", err, 1'b1);
    check("tmo_access_len", enab_len, TIMEOUT_CYCLES);
    check("tmo_apb_idle", {apb_psel, apb_enab}, 2'b00);
    ack_never = 1'b0;
    sb_q.delete();
    push_steps(2'd0, 32'h1, 1);
    pulse_start();
    check("tmo_err_cleared", err, 1'b0);
    wait_steps(1, 100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("tmo_restart_sb", sb_q.size(), 0);
`else
    // Ack never returned: access phase waits indefinitely, err stays low
    do_reset();
    ack_never = 1'b1;
    pulse_start();
    repeat (40) @(negedge clk);
    check("noack_busy", busy, 1'b1);
    check("noack_enab_held", apb_enab, 1'b1);
    check("noack_err", err, 1'b0);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
